spi_master: RTL and testbench
=============================

SPI_MASTER -- requirements
Module: spi_master

Interface
REQ-001 Parameter CLK_DIV, default 4, SCK half-period in clk cycles; legal range 2..255, other values SHALL fail elaboration.
REQ-002 clk  input  1  system clock; all logic on rising edge.
REQ-003 rst  input  1  reset, asynchronous, active-high.
REQ-004 start  input  1  request one byte transfer; sampled every clk.
REQ-005 tx_data  input  8  byte to send, MSB first; captured on accepted start.
REQ-006 busy  output  1  transfer or inter-frame gap in progress.
REQ-007 done  output  1  one-clk pulse, byte complete, rx_data valid.
REQ-008 rx_data  output  8  last received byte; held until next done.
REQ-009 SCK  output  1  SPI clock, mode 0 (CPOL=0, CPHA=0).
REQ-010 SSEL  output  1  slave select, active low.
REQ-011 MOSI  output  1  master data out.
REQ-012 MISO  input  1  slave data in; treated as synchronous to SCK timing, no resync.

Function
REQ-013 States SHALL be IDLE, SETUP, SCK_HI, SCK_LO, HOLD, GAP; one 8-bit divider counter, one 3-bit bit counter.
REQ-014 Start accepted when start=1 and state=IDLE; ignored otherwise (except REQ-025); tx_data changes while busy have no effect.
REQ-015 Cycle after acceptance (T+1): SSEL=0, MOSI=tx_data[7], SCK=0, busy=1, state SETUP for CLK_DIV cycles.
REQ-016 SCK SHALL rise at T+1+CLK_DIV+2k*CLK_DIV and fall at T+1+2*CLK_DIV+2k*CLK_DIV for bit k=0..7.
REQ-017 MOSI SHALL change only on SCK falling edges (next bit MSB-first), never while SCK high.
REQ-018 MISO SHALL be sampled on the clk edge ending each SCK high phase and shifted in MSB-first.
REQ-019 After the 8th falling edge: HOLD for CLK_DIV cycles, SCK=0, SSEL=0, MOSI held at bit 0.
REQ-020 At T+1+17*CLK_DIV: SSEL=1, done=1 for exactly one cycle, rx_data updated same cycle, state GAP.
REQ-021 GAP lasts CLK_DIV cycles with SSEL=1, busy=1; busy SHALL fall at T+1+18*CLK_DIV, state IDLE.
REQ-022 In IDLE: SCK=0, SSEL=1, MOSI=0, busy=0, done=0.
REQ-023 start held high continuously SHALL produce back-to-back frames separated by the GAP (plus one IDLE cycle).

Reset
REQ-024 rst=1 SHALL immediately (without clk) force state IDLE, SCK=0, SSEL=1, MOSI=0, busy=0, done=0, rx_data=8'h00, counters 0; mid-transfer the partial byte SHALL be discarded and no done emitted.

Configuration
REQ-025 Macro SPI_MASTER_BURST_EN defined: start=1 in the cycle done=1 SHALL be accepted, SSEL SHALL remain 0 (no GAP), new tx_data captured, state SETUP; done still pulses for the finished byte.
REQ-026 SPI_MASTER_BURST_EN undefined: SSEL SHALL always deassert after each byte per REQ-020/021; start during done ignored.

Verification
REQ-027 CLK_DIV=4, start at T with tx_data=8'hA5, MISO driven by model returning 8'h3C -> SSEL low T+1..T+68, SCK rises at T+5,13,...,61, MOSI bits 1,0,1,0,0,1,0,1, done and SSEL high at T+69, rx_data=8'h3C, busy low at T+73.
REQ-028 Connected to team's SPI slave, CLK_DIV=4, two frames tx 8'h00 -> first rx_data equals slave message count, second equals count+1.
REQ-029 start pulsed at T and again at T+20 -> second start ignored, exactly one done.
REQ-030 rst asserted at T+30 of a frame -> same-cycle SSEL=1, SCK=0, busy=0; no done; next start yields normal frame timing.
REQ-031 SPI_MASTER_BURST_EN, start held with tx 8'h81 then 8'h7E -> SSEL low continuously 16 SCK pulses, two done pulses, MOSI bits 10000001 01111110.
REQ-032 CLK_DIV=2, tx 8'hFF, MISO tied 0 -> frame length 1+17*2 cycles to done, rx_data=8'h00.

Source files
------------

// File: rtl/spi_master_if.sv
`default_nettype none
// ============================================================================
//  Module      : spi_master_if
//  Description : Host handshake plus SPI pin bundle for spi_master.
//  Revision    : 1.0  initial release
// ============================================================================
interface spi_master_if;
    logic       start;
    logic [7:0] tx_data;
    logic       busy;
    logic       done;
    logic [7:0] rx_data;
    logic       SCK;
    logic       SSEL;
    logic       MOSI;
    logic       MISO;

    modport master (
        input  start, tx_data, MISO,
        output busy, done, rx_data, SCK, SSEL, MOSI
    );

    modport slave (
        output start, tx_data, MISO,
        input  busy, done, rx_data, SCK, SSEL, MOSI
    );
endinterface
`default_nettype wire

// File: rtl/spi_master.sv
`default_nettype none
// ============================================================================
//  Module      : spi_master
//  Description : Mode-0 SPI byte master, MSB first, SCK half-period = CLK_DIV.
//                Define SPI_MASTER_BURST_EN to chain bytes under one SSEL.
//  Revision    : 1.0  initial release
// ============================================================================
module spi_master #(
    parameter int CLK_DIV = 4
) (
    input  logic         clk,
    input  logic         rst,
    spi_master_if.master bus
);

    generate
        if (CLK_DIV < 2 || CLK_DIV > 255) begin : g_bad_clk_div
            $error("spi_master: CLK_DIV must lie in 2..255");
        end
    endgenerate

    localparam logic [7:0] c_div_last = 8'(CLK_DIV - 1);

    localparam logic [2:0] c_idle   = 3'd0;
    localparam logic [2:0] c_setup  = 3'd1;
    localparam logic [2:0] c_sck_hi = 3'd2;
    localparam logic [2:0] c_sck_lo = 3'd3;
    localparam logic [2:0] c_hold   = 3'd4;
    localparam logic [2:0] c_gap    = 3'd5;

    logic [2:0] r_state;
    logic [7:0] r_div;
    logic [2:0] r_bit;
    logic [6:0] r_tx;
    logic [7:0] r_rx;
    logic [7:0] r_rx_data;
    logic       r_sck;
    logic       r_ssel;
    logic       r_mosi;
    logic       r_busy;
    logic       r_done;
    logic       w_div_done;

    assign w_div_done = (r_div == c_div_last);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state   <= c_idle;
            r_div     <= 8'd0;
            r_bit     <= 3'd0;
            r_tx      <= 7'd0;
            r_rx      <= 8'd0;
            r_rx_data <= 8'h00;
            r_sck     <= 1'b0;
            r_ssel    <= 1'b1;
            r_mosi    <= 1'b0;
            r_busy    <= 1'b0;
            r_done    <= 1'b0;
        end else begin
            r_done <= 1'b0;
            case (r_state)
                c_idle: begin
                    r_div  <= 8'd0;
                    r_bit  <= 3'd0;
                    r_sck  <= 1'b0;
                    r_ssel <= 1'b1;
                    r_mosi <= 1'b0;
                    r_busy <= 1'b0;
                    if (bus.start) begin
                        r_state <= c_setup;
                        r_tx    <= bus.tx_data[6:0];
                        r_mosi  <= bus.tx_data[7];
                        r_ssel  <= 1'b0;
                        r_busy  <= 1'b1;
                    end
                end
                c_setup: begin
                    if (w_div_done) begin
                        r_div   <= 8'd0;
                        r_sck   <= 1'b1;
                        r_state <= c_sck_hi;
                    end else begin
                        r_div <= r_div + 8'd1;
                    end
                end
                c_sck_hi: begin
                    if (w_div_done) begin
                        // Falling edge: capture MISO, then present the next bit.
                        r_div <= 8'd0;
                        r_sck <= 1'b0;
                        r_rx  <= {r_rx[6:0], bus.MISO};
                        if (r_bit == 3'd7) begin
                            r_state <= c_hold;
                        end else begin
                            r_state <= c_sck_lo;
                            r_bit   <= r_bit + 3'd1;
                            r_mosi  <= r_tx[6];
                            r_tx    <= {r_tx[5:0], 1'b0};
                        end
                    end else begin
                        r_div <= r_div + 8'd1;
                    end
                end
                c_sck_lo: begin
                    if (w_div_done) begin
                        r_div   <= 8'd0;
                        r_sck   <= 1'b1;
                        r_state <= c_sck_hi;
                    end else begin
                        r_div <= r_div + 8'd1;
                    end
                end
                c_hold: begin
                    if (w_div_done) begin
                        r_div     <= 8'd0;
                        r_done    <= 1'b1;
                        r_rx_data <= r_rx;
                        r_mosi    <= 1'b0;
                        r_state   <= c_gap;
`ifndef SPI_MASTER_BURST_EN
                        r_ssel    <= 1'b1;
`endif
                    end else begin
                        r_div <= r_div + 8'd1;
                    end
                end
                c_gap: begin
`ifdef SPI_MASTER_BURST_EN
                    // SSEL stays low through the done cycle so a chained start keeps the slave selected.
                    if (r_done && bus.start) begin
                        r_state <= c_setup;
                        r_div   <= 8'd0;
                        r_bit   <= 3'd0;
                        r_tx    <= bus.tx_data[6:0];
                        r_mosi  <= bus.tx_data[7];
                    end else begin
                        r_ssel <= 1'b1;
                        if (w_div_done) begin
                            r_div   <= 8'd0;
                            r_busy  <= 1'b0;
                            r_state <= c_idle;
                        end else begin
                            r_div <= r_div + 8'd1;
                        end
                    end
`else
                    if (w_div_done) begin
                        r_div   <= 8'd0;
                        r_busy  <= 1'b0;
                        r_state <= c_idle;
                    end else begin
                        r_div <= r_div + 8'd1;
                    end
`endif
                end
                default: begin
                    r_state <= c_idle;
                end
            endcase
        end
    end

    assign bus.SCK     = r_sck;
    assign bus.SSEL    = r_ssel;
    assign bus.MOSI    = r_mosi;
    assign bus.busy    = r_busy;
    assign bus.done    = r_done;
    assign bus.rx_data = r_rx_data;

endmodule
`default_nettype wire

// File: tb/tb_spi_master.sv
`default_nettype none
// ============================================================================
//  Module      : tb_spi_master
//  Description : Directed self-checking bench for spi_master (CLK_DIV 4 and 2).
//  Revision    : 1.0  initial release
// ============================================================================
module tb_spi_master;

`ifdef SPI_MASTER_BURST_EN
    localparam int c_ssel_last_single = 69;
`else
    localparam int c_ssel_last_single = 68;
`endif

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    logic       r_start = 1'b0;
    logic       r_sel   = 1'b0;
    logic [7:0] r_tx    = 8'h00;

    spi_master_if bus_a ();
    spi_master_if bus_b ();

    spi_master #(.CLK_DIV(4)) u_dut_a (.clk(clk), .rst(rst), .bus(bus_a));
    spi_master #(.CLK_DIV(2)) u_dut_b (.clk(clk), .rst(rst), .bus(bus_b));

    // Slave model on bus_a: mode 0, shifts on SCK fall, reloads per byte
    logic [7:0] s_shift     = 8'h00;
    logic [7:0] s_byte      = 8'h3C;
    logic [7:0] s_msg_cnt   = 8'd5;
    logic       s_use_cnt   = 1'b0;
    int         s_nfall     = 0;
    logic       s_prev_ssel = 1'b1;
    logic       s_prev_sck  = 1'b0;

    always @(negedge clk) begin
        if (s_prev_ssel && !bus_a.SSEL) begin
            s_shift = s_use_cnt ? s_msg_cnt : s_byte;
            s_nfall = 0;
        end else if (s_prev_sck && !bus_a.SCK) begin
            s_nfall = s_nfall + 1;
            if (s_nfall == 8) begin
                s_msg_cnt = s_msg_cnt + 8'd1;
                s_nfall   = 0;
                s_shift   = s_use_cnt ? s_msg_cnt : s_byte;
            end else begin
                s_shift = {s_shift[6:0], 1'b0};
            end
        end
        s_prev_ssel = bus_a.SSEL;
        s_prev_sck  = bus_a.SCK;
    end

    assign bus_a.start   = r_start & ~r_sel;
    assign bus_b.start   = r_start & r_sel;
    assign bus_a.tx_data = r_tx;
    assign bus_b.tx_data = r_tx;
    assign bus_a.MISO    = s_shift[7];
    assign bus_b.MISO    = 1'b0;

    logic       w_sck, w_ssel, w_mosi, w_busy, w_done;
    logic [7:0] w_rx;
    assign w_sck  = r_sel ? bus_b.SCK     : bus_a.SCK;
    assign w_ssel = r_sel ? bus_b.SSEL    : bus_a.SSEL;
    assign w_mosi = r_sel ? bus_b.MOSI    : bus_a.MOSI;
    assign w_busy = r_sel ? bus_b.busy    : bus_a.busy;
    assign w_done = r_sel ? bus_b.done    : bus_a.done;
    assign w_rx   = r_sel ? bus_b.rx_data : bus_a.rx_data;

    int n_checks = 0;
    int n_errors = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    int          cap_rise [16];
    int          cap_nrise;
    logic [15:0] cap_mosi;
    int          cap_mosi_bad;
    int          cap_ssel_first, cap_ssel_last, cap_ssel_breaks;
    int          cap_done [4];
    logic [7:0]  cap_rx   [4];
    int          cap_ndone;
    int          cap_busy_fall;

    // Cycle k of the capture loop is T+k, T being the cycle start is first high.
    task automatic run_frame(input logic [7:0] tx, input int ncyc, input int hold_until,
                             input int extra_at, input logic [7:0] tx2, input int tx2_at);
        logic p_sck, p_ssel, p_mosi, p_busy;
        for (int i = 0; i < 16; i++) cap_rise[i] = -1;
        for (int i = 0; i < 4; i++) begin
            cap_done[i] = -1;
            cap_rx[i]   = 8'hxx;
        end
        cap_nrise = 0; cap_mosi = 16'h0; cap_mosi_bad = 0;
        cap_ssel_first = -1; cap_ssel_last = -1; cap_ssel_breaks = 0;
        cap_ndone = 0; cap_busy_fall = -1;
        @(negedge clk);
        p_sck = w_sck; p_ssel = w_ssel; p_mosi = w_mosi; p_busy = w_busy;
        r_tx    = tx;
        r_start = 1'b1;
        for (int k = 1; k <= ncyc; k++) begin
            @(negedge clk);
            if (w_sck && !p_sck) begin
                if (cap_nrise < 16) cap_rise[cap_nrise] = k;
                cap_nrise++;
                cap_mosi = {cap_mosi[14:0], w_mosi};
            end
            if (w_sck && (w_mosi !== p_mosi)) cap_mosi_bad++;
            if (!w_ssel) begin
                if (cap_ssel_first < 0) cap_ssel_first = k;
                else if (p_ssel) cap_ssel_breaks++;
                cap_ssel_last = k;
            end
            if (w_done) begin
                if (cap_ndone < 4) begin
                    cap_done[cap_ndone] = k;
                    cap_rx[cap_ndone]   = w_rx;
                end
                cap_ndone++;
            end
            if (!w_busy && p_busy && cap_busy_fall < 0) cap_busy_fall = k;
            p_sck = w_sck; p_ssel = w_ssel; p_mosi = w_mosi; p_busy = w_busy;
            r_start = (k < hold_until) || (k + 1 == extra_at);
            if (k == tx2_at) r_tx = tx2;
        end
        r_start = 1'b0;
    endtask

    logic [7:0] exp_cnt;
    int         n_done_after_rst;
    int         n_busy_after_rst;

    initial begin
        repeat (3) @(negedge clk);
        check("rst_sck",  bus_a.SCK,     1'b0);
        check("rst_ssel", bus_a.SSEL,    1'b1);
        check("rst_mosi", bus_a.MOSI,    1'b0);
        check("rst_busy", bus_a.busy,    1'b0);
        check("rst_done", bus_a.done,    1'b0);
        check("rst_rx",   bus_a.rx_data, 8'h00);
        rst = 1'b0;
        repeat (2) @(negedge clk);

        // Reference frame: A5 out, 3C back; tx_data disturbed mid-frame
        s_byte = 8'h3C;
        run_frame(8'hA5, 80, 1, 0, 8'h00, 10);
        check("a5_nrise",      cap_nrise,      8);
        check("a5_rise0",      cap_rise[0],    5);
        check("a5_rise1",      cap_rise[1],    13);
        check("a5_rise7",      cap_rise[7],    61);
        check("a5_mosi",       cap_mosi[7:0],  8'hA5);
        check("a5_mosi_sckhi", cap_mosi_bad,   0);
        check("a5_ssel_first", cap_ssel_first, 1);
        check("a5_ssel_last",  cap_ssel_last,  c_ssel_last_single);
        check("a5_ndone",      cap_ndone,      1);
        check("a5_done_cyc",   cap_done[0],    69);
        check("a5_rx",         cap_rx[0],      8'h3C);
        check("a5_busy_fall",  cap_busy_fall,  73);
        check("a5_rx_held",    w_rx,           8'h3C);
        check("a5_idle_mosi",  w_mosi,         1'b0);

        // Second start while busy is ignored
        s_byte = 8'hC3;
        run_frame(8'h5A, 90, 1, 20, 8'h5A, 0);
        check("dbl_ndone",    cap_ndone,     1);
        check("dbl_done_cyc", cap_done[0],   69);
        check("dbl_nrise",    cap_nrise,     8);
        check("dbl_mosi",     cap_mosi[7:0], 8'h5A);
        check("dbl_rx",       cap_rx[0],     8'hC3);

`ifdef SPI_MASTER_BURST_EN
        // Start held: second byte chained at the done cycle under one SSEL
        s_byte = 8'h99;
        run_frame(8'h81, 150, 70, 0, 8'h7E, 10);
        check("burst_nrise",  cap_nrise,       16);
        check("burst_mosi",   cap_mosi,        16'h817E);
        check("burst_ndone",  cap_ndone,       2);
        check("burst_done0",  cap_done[0],     69);
        check("burst_done1",  cap_done[1],     138);
        check("burst_breaks", cap_ssel_breaks, 0);
        check("burst_ssel_l", cap_ssel_last,   138);
        check("burst_rx1",    cap_rx[1],       8'h99);
`else
        // Start held: two frames separated by GAP plus one IDLE cycle
        s_byte = 8'h42;
        run_frame(8'h96, 150, 75, 0, 8'h96, 0);
        check("b2b_ndone",  cap_ndone,       2);
        check("b2b_done0",  cap_done[0],     69);
        check("b2b_done1",  cap_done[1],     142);
        check("b2b_rise8",  cap_rise[8],     78);
        check("b2b_breaks", cap_ssel_breaks, 1);
        check("b2b_mosi",   cap_mosi,        16'h9696);
        check("b2b_rx1",    cap_rx[1],       8'h42);
`endif

        // Slave answering with its message counter
        s_use_cnt = 1'b1;
        exp_cnt   = s_msg_cnt;
        run_frame(8'h00, 80, 1, 0, 8'h00, 0);
        check("cnt_rx0",   cap_rx[0],     exp_cnt);
        check("cnt_mosi0", cap_mosi[7:0], 8'h00);
        run_frame(8'h00, 80, 1, 0, 8'h00, 0);
        check("cnt_rx1",   cap_rx[0],     exp_cnt + 8'd1);
        s_use_cnt = 1'b0;

        // Asynchronous reset in the middle of bit 3's high phase
        s_byte = 8'hE7;
        r_tx   = 8'hC3;
        @(negedge clk);
        r_start = 1'b1;
        @(negedge clk);
        r_start = 1'b0;
        repeat (28) @(negedge clk);
        @(posedge clk);
        #2;
        check("mid_sck_before", bus_a.SCK, 1'b1);
        rst = 1'b1;
        #1;
        check("mid_rst_ssel", bus_a.SSEL, 1'b1);
        check("mid_rst_sck",  bus_a.SCK,  1'b0);
        check("mid_rst_busy", bus_a.busy, 1'b0);
        check("mid_rst_mosi", bus_a.MOSI, 1'b0);
        @(negedge clk);
        rst = 1'b0;
        n_done_after_rst = 0;
        n_busy_after_rst = 0;
        for (int k = 0; k < 80; k++) begin
            @(negedge clk);
            if (bus_a.done) n_done_after_rst++;
            if (bus_a.busy) n_busy_after_rst++;
        end
        check("mid_rst_ndone", n_done_after_rst, 0);
        check("mid_rst_nbusy", n_busy_after_rst, 0);
        check("mid_rst_rx",    bus_a.rx_data,    8'h00);
        run_frame(8'h3C, 80, 1, 0, 8'h3C, 0);
        check("post_rst_done", cap_done[0],   69);
        check("post_rst_rise", cap_rise[0],   5);
        check("post_rst_busy", cap_busy_fall, 73);
        check("post_rst_rx",   cap_rx[0],     8'hE7);
        check("post_rst_mosi", cap_mosi[7:0], 8'h3C);

        // CLK_DIV=2 instance, MISO tied low
        r_sel = 1'b1;
        @(negedge clk);
        run_frame(8'hFF, 50, 1, 0, 8'hFF, 0);
        check("div2_done_cyc",  cap_done[0],   35);
        check("div2_ndone",     cap_ndone,     1);
        check("div2_rx",        cap_rx[0],     8'h00);
        check("div2_rise0",     cap_rise[0],   3);
        check("div2_rise7",     cap_rise[7],   31);
        check("div2_mosi",      cap_mosi[7:0], 8'hFF);
        check("div2_busy_fall", cap_busy_fall, 37);
        r_sel = 1'b0;

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
`default_nettype wire
